// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the 16-bit processor core decode and its program sequencer:
// instruction fields, opcodes and sequencer state encoding.
package proc_sequencer_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 0;
  localparam int OP_W    = 4;
  localparam int X_LSB   = 4;
  localparam int Y_LSB   = 7;
  localparam int REG_W   = 3;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [OP_W-1:0]    opcode_t;
  typedef logic [REG_W-1:0]   reg_sel_t;

  localparam opcode_t OP_MV   = 4'b0000;
  localparam opcode_t OP_MVI  = 4'b0001;
  localparam opcode_t OP_ADD  = 4'b0010;
  localparam opcode_t OP_HALT = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_IFETCH,
    S_IWAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_ERROR
  } seq_state_t;

  function automatic opcode_t get_opcode(input instr_t w);
    return w[OP_LSB +: OP_W];
  endfunction

  function automatic reg_sel_t get_x(input instr_t w);
    return w[X_LSB +: REG_W];
  endfunction

  function automatic reg_sel_t get_y(input instr_t w);
    return w[Y_LSB +: REG_W];
  endfunction

  // Words occupied in program memory; unknown opcodes behave as single-word mv.
  function automatic logic [1:0] op_words(input opcode_t op);
    case (op)
      OP_MVI:         return 2'd2;
      OP_MV, OP_ADD:  return 2'd1;
      default:        return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/proc_sequencer_exec_watchdog.sv
// Execute-phase watchdog: clearable/loadable up-counter that flags the cycle in which
// the count reaches TIMEOUT_CYC.
module exec_watchdog #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr_i,
  input  logic                             load_i,
  input  logic [$clog2(TIMEOUT_CYC+1)-1:0] load_val_i,
  input  logic                             inc_i,
  output logic                             expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the cycles already spent, so this is the cycle that makes it TIMEOUT_CYC.
  assign expire_o = inc_i && (cnt_q >= CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Program sequencer: fetches instructions (and mvi immediates) from a synchronous ROM,
// drives the core's DIN/Run, advances pc on Done and detects halt, end and hang.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int PROG_LEN    = 256,
  parameter int TIMEOUT_CYC = 15,
  parameter int CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] PROG_END  = PW'(PROG_LEN);
  localparam logic [PW-1:0] LAST_ADDR = PW'(PROG_LEN - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  instr_t            instr_q, instr_d;
  instr_t            imm_q, imm_d;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              busy_q, halted_q, error_q;

  logic              wd_clr, wd_inc, wd_expire;
  logic [PW-1:0]     pc_ext, pc_next;

  assign pc_ext  = {1'b0, pc_q};
  // Extra bit lets the end-of-program check see PROG_LEN even when it equals 2**ADDR_W.
  assign pc_next = pc_ext + PW'(op_words(get_opcode(instr_q)));

  exec_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk        (Clock),
    .rst_n      (Resetn),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (wd_inc),
    .expire_o   (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        instr_d = mem_data;
        if (get_opcode(mem_data) == OP_HALT) begin
          state_d = S_HALT;
        end else if (get_opcode(mem_data) == OP_MVI) begin
          // An immediate beyond the last valid word can never be fetched.
          state_d = (pc_ext == LAST_ADDR) ? S_ERROR : S_IFETCH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_IFETCH: state_d = S_IWAIT;
      S_IWAIT: begin
        imm_d   = mem_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wd_inc = 1'b1;
        if (Done) begin
          retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;
          pc_d      = pc_next[ADDR_W-1:0];
          state_d   = (pc_next >= PROG_END) ? S_HALT : S_FETCH;
        end else if (wd_expire) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      retired_q  <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      mem_rd_q   <= (state_d == S_FETCH) || (state_d == S_IFETCH);
      mem_addr_q <= (state_d == S_IFETCH) ? pc_d + 1'b1 : pc_d;
      busy_q     <= !(state_d inside {S_IDLE, S_HALT, S_ERROR});
      halted_q   <= (state_d == S_HALT);
      error_q    <= (state_d == S_ERROR);
    end
  end

  // Run and DIN come only from registers, so Done never reaches them combinationally.
  assign Run      = (state_q == S_ISSUE) || (state_q == S_EXEC);
  assign DIN      = ((state_q == S_EXEC) && (get_opcode(instr_q) == OP_MVI)) ? imm_q : instr_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign Busy     = busy_q;
  assign Halted   = halted_q;
  assign Error    = error_q;
  assign pc       = pc_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: directed ROM programs with a simple core model;
// expectations are queued by the stimulus and consumed by independent monitors.
`timescale 1ns/1ps
module tb_proc_sequencer;

  localparam int ADDR_W      = 8;
  localparam int PROG_LEN    = 3;
  localparam int TIMEOUT_CYC = 6;
  localparam int CNT_W       = 16;

  logic              Clock  = 1'b0;
  logic              Resetn = 1'b1;
  logic              Start  = 1'b0;
  logic              Done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic [15:0]       DIN;
  logic              Run, Busy, Halted, Error;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  retired;

  always #5 Clock = ~Clock;

  proc_sequencer #(
    .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy), .Halted(Halted),
    .Error(Error), .pc(pc), .retired(retired)
  );

  // Synchronous ROM: data appears the cycle after the read strobe.
  logic [15:0] rom [0:7];
  logic [15:0] rom_q = 16'h0000;
  always @(posedge Clock) if (mem_rd) rom_q <= rom[mem_addr[2:0]];
  assign mem_data = rom_q;

  // Core model: Tstep 0 is the first Run cycle; Done is raised in Tstep done_step.
  int tstep = 0;
  int done_step = 1;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn)   tstep <= 0;
    else if (!Run) tstep <= 0;
    else           tstep <= tstep + 1;
  end
  assign Done = Run && (tstep == done_step);

  typedef struct packed {
    logic              busy, halted, error, run, rd;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  retired;
  } status_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual 0x%0h observed with no expectation queued (t=%0t)", name, act, $time);
  endtask

  function automatic status_t mk_status(input logic busy, halted, error, run, rd,
                                        input int p, input int r);
    return {busy, halted, error, run, rd, ADDR_W'(p), CNT_W'(r)};
  endfunction

  function automatic status_t cur_status();
    return {Busy, Halted, Error, Run, mem_rd, pc, retired};
  endfunction

  // Scoreboard queues
  int          exp_fetch[$];
  logic [15:0] exp_din[$];
  int          exp_run_len[$];
  int          exp_gap[$];
  status_t     exp_end[$];
  status_t     exp_probe[$];
  status_t     exp_rst[$];
  logic [15:0] exp_rst_din[$];
  event        probe_ev;

  // Cycle monitor: fetches, issued words, Run burst lengths, Run-low gaps, end state.
  int   run_len    = 0;
  int   gap        = 0;
  bit   gap_active = 1'b0;
  logic prev_run   = 1'b0;
  logic prev_busy  = 1'b0;

  initial forever begin
    @(negedge Clock);
    if (!Resetn) begin
      run_len = 0; gap = 0; gap_active = 1'b0; prev_run = 1'b0; prev_busy = 1'b0;
    end else begin
      if (mem_rd) begin
        if (exp_fetch.size() == 0) unexpected("fetch_addr", 64'(mem_addr));
        else check("fetch_addr", 64'(mem_addr), 64'(exp_fetch.pop_front()));
      end
      if (Run) begin
        if (exp_din.size() == 0) unexpected("din", 64'(DIN));
        else check("din", 64'(DIN), 64'(exp_din.pop_front()));
        if (!prev_run && gap_active) begin
          if (exp_gap.size() == 0) unexpected("run_gap", 64'(gap));
          else check("run_gap", 64'(gap), 64'(exp_gap.pop_front()));
        end
        gap_active = 1'b0;
        run_len++;
      end else begin
        if (prev_run) begin
          if (exp_run_len.size() == 0) unexpected("run_len", 64'(run_len));
          else check("run_len", 64'(run_len), 64'(exp_run_len.pop_front()));
          run_len = 0; gap = 0; gap_active = 1'b1;
        end
        if (!Busy) gap_active = 1'b0;
        if (gap_active) gap++;
      end
      if (prev_busy && !Busy) begin
        if (exp_end.size() == 0) unexpected("end_status", 64'(cur_status()));
        else check("end_status", 64'(cur_status()), 64'(exp_end.pop_front()));
      end
      prev_run  = Run;
      prev_busy = Busy;
    end
  end

  // Asynchronous reset monitor: outputs must clear without waiting for a clock edge.
  initial forever begin
    @(negedge Resetn);
    #1;
    if (exp_rst.size() == 0) unexpected("reset_status", 64'(cur_status()));
    else check("reset_status", 64'(cur_status()), 64'(exp_rst.pop_front()));
    if (exp_rst_din.size() == 0) unexpected("reset_din", 64'(DIN));
    else check("reset_din", 64'(DIN), 64'(exp_rst_din.pop_front()));
  end

  initial forever begin
    @(probe_ev);
    if (exp_probe.size() == 0) unexpected("probe_status", 64'(cur_status()));
    else check("probe_status", 64'(cur_status()), 64'(exp_probe.pop_front()));
  end

  task automatic load_rom(input logic [15:0] w0, w1, w2);
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    rom[0] = w0; rom[1] = w1; rom[2] = w2;
  endtask

  task automatic push_fetch(input int a);
    exp_fetch.push_back(a);
  endtask

  task automatic push_din(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) exp_din.push_back(d);
  endtask

  task automatic pulse_start();
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (!Busy) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: still Busy after 300 cycles, required idle", name);
    end
  endtask

  task automatic probe_after(input int cycles, input status_t exp);
    exp_probe.push_back(exp);
    repeat (cycles) @(negedge Clock);
    -> probe_ev;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit found;

    // Power-on reset and idle hold
    exp_rst.push_back(mk_status(0, 0, 0, 0, 0, 0, 0));
    exp_rst_din.push_back(16'h0000);
    #3  Resetn = 1'b0;
    #19 Resetn = 1'b1;
    probe_after(3, mk_status(0, 0, 0, 0, 0, 0, 0));

    // mv then halt, Done in Tstep 1
    load_rom(16'h0000, 16'h000F, 16'h0000); done_step = 1;
    push_fetch(0); push_din(16'h0000, 2); exp_run_len.push_back(2); push_fetch(1);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 1, 1));
    pulse_start(); wait_idle("prog_mv_halt");

    // mvi: instruction word in ISSUE, immediate for the rest of EXEC, pc 0 -> 2
    load_rom(16'h0001, 16'h1234, 16'h000F); done_step = 1;
    push_fetch(0); push_fetch(1); push_din(16'h0001, 1); push_din(16'h1234, 1);
    exp_run_len.push_back(2); push_fetch(2);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 2, 1));
    pulse_start(); wait_idle("prog_mvi");

    // add with Done in Tstep 3 -> Run high 4 cycles
    load_rom(16'h0012, 16'h000F, 16'h0000); done_step = 3;
    push_fetch(0); push_din(16'h0012, 4); exp_run_len.push_back(4); push_fetch(1);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 1, 1));
    pulse_start(); wait_idle("prog_add");

    // Done in the very cycle the watchdog expires still counts as completion
    load_rom(16'h0000, 16'h000F, 16'h0000); done_step = TIMEOUT_CYC;
    push_fetch(0); push_din(16'h0000, TIMEOUT_CYC + 1); exp_run_len.push_back(TIMEOUT_CYC + 1);
    push_fetch(1);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 1, 1));
    pulse_start(); wait_idle("prog_done_at_expiry");

    // Hung instruction (unlisted opcode 0x5 issues like mv): Error after TIMEOUT_CYC EXEC cycles
    load_rom(16'h0005, 16'h000F, 16'h0000); done_step = 99;
    push_fetch(0); push_din(16'h0005, TIMEOUT_CYC + 1); exp_run_len.push_back(TIMEOUT_CYC + 1);
    exp_end.push_back(mk_status(0, 0, 1, 0, 0, 0, 0));
    pulse_start(); wait_idle("prog_timeout");
    probe_after(2, mk_status(0, 0, 1, 0, 0, 0, 0));

    // Start from ERROR clears Error and reruns from pc 0
    load_rom(16'h0000, 16'h000F, 16'h0000); done_step = 1;
    push_fetch(0); push_din(16'h0000, 2); exp_run_len.push_back(2); push_fetch(1);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 1, 1));
    pulse_start(); wait_idle("prog_rerun_after_error");

    // Three mv words, no halt: end-of-program at pc 3; stray Start while Busy is ignored.
    // Done edge to next Run rise spans FETCH and WAIT with Run low: 2 low samples.
    load_rom(16'h0000, 16'h0000, 16'h0000); done_step = 1;
    for (int i = 0; i < 3; i++) begin
      push_fetch(i); push_din(16'h0000, 2); exp_run_len.push_back(2);
    end
    exp_gap.push_back(2); exp_gap.push_back(2);
    exp_end.push_back(mk_status(0, 1, 0, 0, 0, 3, 3));
    pulse_start();
    repeat (4) @(negedge Clock);
    pulse_start();
    wait_idle("prog_end_of_program");

    // mvi in the last valid word: Error with no immediate fetch and no issue
    load_rom(16'h0000, 16'h0000, 16'h0001); done_step = 1;
    push_fetch(0); push_din(16'h0000, 2); exp_run_len.push_back(2); exp_gap.push_back(2);
    push_fetch(1); push_din(16'h0000, 2); exp_run_len.push_back(2); push_fetch(2);
    exp_end.push_back(mk_status(0, 0, 1, 0, 0, 2, 2));
    pulse_start(); wait_idle("prog_mvi_at_end");

    // Reset during EXEC of an add at pc 1
    load_rom(16'h0000, 16'h0012, 16'h000F); done_step = 3;
    push_fetch(0); push_din(16'h0000, 4); exp_run_len.push_back(4); exp_gap.push_back(2);
    push_fetch(1); push_din(16'h0012, 3);
    exp_rst.push_back(mk_status(0, 0, 0, 0, 0, 0, 0));
    exp_rst_din.push_back(16'h0000);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Run && (pc == ADDR_W'(1)) && (tstep == 2)) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_window: add EXEC Tstep 2 never reached, required within 100 cycles");
    end
    #2  Resetn = 1'b0;
    #12 Resetn = 1'b1;
    probe_after(6, mk_status(0, 0, 0, 0, 0, 0, 0));

    check("scoreboard_drained",
          64'(exp_fetch.size() + exp_din.size() + exp_run_len.size() + exp_gap.size() +
              exp_end.size() + exp_probe.size() + exp_rst.size() + exp_rst_din.size()),
          64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
